// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// alu_mc : registered ALU with single-cycle ops plus iterative MUL/DIV
//          behind a START/BUSY/DONE handshake.
// Revision: 1.0
// ============================================================================
module alu_mc #(
    parameter int IWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [IWIDTH-1:0] in_instr_i,
    input  logic [DWIDTH-1:0] in_a_i,
    input  logic [DWIDTH-1:0] in_b_i,
    output logic [DWIDTH-1:0] out_o,
    output logic [DWIDTH-1:0] out_h_o,
    output logic [3:0]        flags_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CW  = $clog2(DWIDTH + 1);
    localparam int MSB = DWIDTH - 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [IWIDTH-1:0] OP_NOT  = IWIDTH'(4'h0);
    localparam logic [IWIDTH-1:0] OP_XOR  = IWIDTH'(4'h1);
    localparam logic [IWIDTH-1:0] OP_OR   = IWIDTH'(4'h2);
    localparam logic [IWIDTH-1:0] OP_AND  = IWIDTH'(4'h3);
    localparam logic [IWIDTH-1:0] OP_SUB  = IWIDTH'(4'h4);
    localparam logic [IWIDTH-1:0] OP_ADD  = IWIDTH'(4'h5);
    localparam logic [IWIDTH-1:0] OP_RR   = IWIDTH'(4'h6);
    localparam logic [IWIDTH-1:0] OP_RL   = IWIDTH'(4'h7);
    localparam logic [IWIDTH-1:0] OP_DEC  = IWIDTH'(4'h8);
    localparam logic [IWIDTH-1:0] OP_INC  = IWIDTH'(4'h9);
    localparam logic [IWIDTH-1:0] OP_ADC  = IWIDTH'(4'hA);
    localparam logic [IWIDTH-1:0] OP_SBB  = IWIDTH'(4'hB);
    localparam logic [IWIDTH-1:0] OP_MUL  = IWIDTH'(4'hC);
    localparam logic [IWIDTH-1:0] OP_DIV  = IWIDTH'(4'hD);
    localparam logic [IWIDTH-1:0] OP_CMP  = IWIDTH'(4'hE);
    localparam logic [IWIDTH-1:0] OP_PASS = IWIDTH'(4'hF);

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [DWIDTH-1:0] out_q, out_h_q;
    logic [3:0]        flags_q;
    logic              done_q;
    logic              is_div_q;
    logic [DWIDTH-1:0] opnd_q;
    logic [DWIDTH-1:0] hi_q, lo_q;

    logic              w_accept, w_long, w_last;
    logic [DWIDTH:0]   w_cin;
    logic [DWIDTH:0]   w_wide;
    logic [DWIDTH-1:0] w_res, w_res_h;
    logic              w_c, w_v;
    logic [3:0]        w_flags;
    logic [DWIDTH:0]   w_mul_sum, w_rem_sh, w_trial;
    logic [DWIDTH-1:0] w_hi_nxt, w_lo_nxt;

    assign w_accept = start_i && (state_q == S_IDLE);
    assign w_long   = w_accept && ((in_instr_i == OP_MUL) ||
                                   ((in_instr_i == OP_DIV) && (|in_b_i)));
    assign w_last   = (state_q == S_RUN) && (cnt_q == CW'(1));
    assign w_cin    = {{DWIDTH{1'b0}}, flags_q[1]};

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_long) state_d = S_RUN;
            S_RUN:   if (w_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == S_RUN);
    end

    // ------------------------------------------------------------------
    // Single-cycle result and flags from the live inputs
    // ------------------------------------------------------------------
    always_comb begin
        w_res   = '0;
        w_res_h = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_wide  = '0;
        case (in_instr_i)
            OP_NOT:  w_res = ~in_a_i;
            OP_XOR:  w_res = in_a_i ^ in_b_i;
            OP_OR:   w_res = in_a_i | in_b_i;
            OP_AND:  w_res = in_a_i & in_b_i;
            OP_SUB, OP_SBB, OP_CMP: begin
                w_wide = {1'b0, in_a_i} - {1'b0, in_b_i}
                       - ((in_instr_i == OP_SBB) ? w_cin : '0);
                w_res  = w_wide[MSB:0];
                w_c    = w_wide[DWIDTH];
                w_v    = (in_a_i[MSB] != in_b_i[MSB]) && (w_res[MSB] != in_a_i[MSB]);
            end
            OP_ADD, OP_ADC: begin
                w_wide = {1'b0, in_a_i} + {1'b0, in_b_i}
                       + ((in_instr_i == OP_ADC) ? w_cin : '0);
                w_res  = w_wide[MSB:0];
                w_c    = w_wide[DWIDTH];
                w_v    = (in_a_i[MSB] == in_b_i[MSB]) && (w_res[MSB] != in_a_i[MSB]);
            end
            OP_RR: begin
                w_res = {1'b0, in_a_i[MSB:1]};
                w_c   = in_a_i[0];
            end
            OP_RL: begin
                w_res = {in_a_i[MSB-1:0], 1'b0};
                w_c   = in_a_i[MSB];
            end
            OP_DEC: begin
                w_wide = {1'b0, in_a_i} - (DWIDTH + 1)'(1);
                w_res  = w_wide[MSB:0];
                w_c    = w_wide[DWIDTH];
                w_v    = in_a_i[MSB] && !w_res[MSB];
            end
            OP_INC: begin
                w_wide = {1'b0, in_a_i} + (DWIDTH + 1)'(1);
                w_res  = w_wide[MSB:0];
                w_c    = w_wide[DWIDTH];
                w_v    = !in_a_i[MSB] && w_res[MSB];
            end
            OP_DIV: begin
                // Only the divide-by-zero case completes here
                w_res   = '1;
                w_res_h = in_a_i;
                w_c     = 1'b1;
            end
            OP_PASS: w_res = in_b_i;
            default: w_res = '0;
        endcase
        w_flags = {w_v, w_res[MSB], w_c, (w_res == '0)};
    end

    // ------------------------------------------------------------------
    // One MUL (shift-add) or DIV (restoring) iteration
    // ------------------------------------------------------------------
    always_comb begin
        w_mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        w_rem_sh  = {hi_q, lo_q[MSB]};
        w_trial   = w_rem_sh - {1'b0, opnd_q};
        if (is_div_q) begin
            if (w_trial[DWIDTH]) begin
                w_hi_nxt = w_rem_sh[MSB:0];
                w_lo_nxt = {lo_q[MSB-1:0], 1'b0};
            end else begin
                w_hi_nxt = w_trial[MSB:0];
                w_lo_nxt = {lo_q[MSB-1:0], 1'b1};
            end
        end else begin
            {w_hi_nxt, w_lo_nxt} = {w_mul_sum, lo_q[MSB:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q    <= '0;
            out_h_q  <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (w_long) begin
                is_div_q <= (in_instr_i == OP_DIV);
                opnd_q   <= (in_instr_i == OP_DIV) ? in_b_i : in_a_i;
                lo_q     <= (in_instr_i == OP_DIV) ? in_a_i : in_b_i;
                hi_q     <= '0;
                cnt_q    <= CW'(DWIDTH);
            end else if (w_accept) begin
                if (in_instr_i != OP_CMP) begin
                    out_q   <= w_res;
                    out_h_q <= w_res_h;
                end
                flags_q <= w_flags;
                done_q  <= 1'b1;
            end else if (state_q == S_RUN) begin
                hi_q  <= w_hi_nxt;
                lo_q  <= w_lo_nxt;
                cnt_q <= cnt_q - CW'(1);
                if (w_last) begin
                    out_q   <= w_lo_nxt;
                    out_h_q <= w_hi_nxt;
                    flags_q <= {1'b0, w_lo_nxt[MSB], !is_div_q && (|w_hi_nxt),
                                (w_lo_nxt == '0)};
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign out_o   = out_q;
    assign out_h_o = out_h_q;
    assign flags_o = flags_q;
    assign done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// tb_alu_mc : directed + randomized bench for alu_mc against an arithmetic model
// Revision: 1.0
// ============================================================================
module tb_alu_mc;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam longint M = longint'(1) << DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] instr = '0;
    logic [DW-1:0] ina = '0, inb = '0;
    logic [DW-1:0] out, out_h;
    logic [3:0]    flags;
    logic          busy, done;

    int n_chk = 0;
    int n_err = 0;

    // Model state: what the outputs must read after the upcoming edge
    logic [DW-1:0] m_out = '0, m_outh = '0;
    logic [3:0]    m_flags = '0;
    logic          m_busy = 1'b0, m_done = 1'b0;
    int            m_left = 0;
    logic [DW-1:0] p_out, p_outh;
    logic [3:0]    p_flags;

    alu_mc #(.IWIDTH(IW), .DWIDTH(DW)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .in_instr_i (instr),
        .in_a_i     (ina),
        .in_b_i     (inb),
        .out_o      (out),
        .out_h_o    (out_h),
        .flags_o    (flags),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit ovf(input longint x);
        return (x > M / 2 - 1) || (x < -(M / 2));
    endfunction

    function automatic longint sgn(input longint x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    task automatic ref_op(input logic [3:0] op, input longint a, input longint b,
                          input longint cin, output longint res, output longint resh,
                          output logic [3:0] fl);
        longint s;
        bit c, v;
        res = 0; resh = 0; c = 0; v = 0;
        case (op)
            4'h0: res = (M - 1) - a;
            4'h1: res = a ^ b;
            4'h2: res = a | b;
            4'h3: res = a & b;
            4'h4, 4'hE: begin s = a - b; c = s < 0; res = (s + M) % M; v = ovf(sgn(a) - sgn(b)); end
            4'h5: begin s = a + b; c = s >= M; res = s % M; v = ovf(sgn(a) + sgn(b)); end
            4'h6: begin res = a / 2; c = (a % 2) == 1; end
            4'h7: begin res = (a * 2) % M; c = a >= M / 2; end
            4'h8: begin s = a - 1; c = s < 0; res = (s + M) % M; v = ovf(sgn(a) - 1); end
            4'h9: begin s = a + 1; c = s >= M; res = s % M; v = ovf(sgn(a) + 1); end
            4'hA: begin s = a + b + cin; c = s >= M; res = s % M; v = ovf(sgn(a) + sgn(b) + cin); end
            4'hB: begin s = a - b - cin; c = s < 0; res = (s + M) % M; v = ovf(sgn(a) - sgn(b) - cin); end
            4'hC: begin s = a * b; res = s % M; resh = s / M; c = resh != 0; end
            4'hD: begin
                if (b == 0) begin res = M - 1; resh = a; c = 1; end
                else begin res = a / b; resh = a % b; end
            end
            default: res = b;
        endcase
        fl = {v, res >= M / 2, c, res == 0};
    endtask

    task automatic model_reset();
        m_out = '0; m_outh = '0; m_flags = '0;
        m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    endtask

    task automatic model_step(input bit st, input logic [3:0] op, input logic [DW-1:0] a,
                              input logic [DW-1:0] b);
        longint r, rh;
        logic [3:0] f;
        m_done = 1'b0;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1;
                m_out = p_out; m_outh = p_outh; m_flags = p_flags;
            end
        end else if (st) begin
            ref_op(op, longint'(a), longint'(b), longint'(m_flags[1]), r, rh, f);
            if (op == 4'hC || (op == 4'hD && b != 0)) begin
                m_busy = 1'b1; m_left = DW;
                p_out = DW'(r); p_outh = DW'(rh); p_flags = f;
            end else begin
                m_done = 1'b1;
                m_flags = f;
                if (op != 4'hE) begin
                    m_out = DW'(r); m_outh = DW'(rh);
                end
            end
        end
    endtask

    // Drive one cycle starting from a falling edge; returns at the next falling edge
    task automatic cycle(input bit st, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
        start = st; instr = op; ina = a; inb = b;
        model_step(st, op, a, b);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        chk("busy",  {15'd0, busy}, {15'd0, m_busy});
        chk("done",  {15'd0, done}, {15'd0, m_done});
        chk("out",   {8'd0, out},   {8'd0, m_out});
        chk("out_h", {8'd0, out_h}, {8'd0, m_outh});
        chk("flags", {12'd0, flags}, {12'd0, m_flags});
    end

    initial begin
        int n;
        logic [3:0] op;
        logic [DW-1:0] a, b;
        logic [DW-1:0] spec [4];
        spec[0] = 8'h00; spec[1] = 8'h7F; spec[2] = 8'h80; spec[3] = 8'hFF;

        repeat (2) @(negedge clk);
        chk("rst_out", {8'd0, out}, 16'h0000);
        chk("rst_flags", {12'd0, flags}, 16'h0000);
        chk("rst_busy_done", {14'd0, busy, done}, 16'h0000);
        rst_n = 1'b1;

        cycle(1, 4'h5, 8'hFF, 8'h01);
        chk("add_out", {8'd0, out}, 16'h0000);
        chk("add_flags", {12'd0, flags}, 16'h0003);
        cycle(1, 4'hA, 8'h10, 8'h20);
        chk("adc_out", {8'd0, out}, 16'h0031);
        chk("adc_flags_done", {11'd0, flags, done}, 16'h0001);
        cycle(1, 4'h4, 8'h80, 8'h01);
        chk("sub_out", {8'd0, out}, 16'h007F);
        chk("sub_flags", {12'd0, flags}, 16'h0008);
        cycle(1, 4'hE, 8'h05, 8'h05);
        chk("cmp_out", {8'd0, out}, 16'h007F);
        chk("cmp_flags", {12'd0, flags}, 16'h0001);

        cycle(1, 4'hC, 8'hFF, 8'hFF);
        n = 0;
        while (busy && n < 20) begin
            n++;
            cycle(n == 3, 4'h5, 8'(n), 8'h11);
        end
        chk("mul_busy_cycles", 16'(n), 16'd8);
        chk("mul_res", {out_h, out}, 16'hFE01);
        chk("mul_flags_done", {11'd0, flags, done}, 16'h0005);

        cycle(1, 4'hD, 8'd200, 8'd7);
        n = 0;
        while (busy && n < 20) begin
            n++;
            cycle(0, 4'h0, $urandom, $urandom);
        end
        chk("div_busy_cycles", 16'(n), 16'd8);
        chk("div_res", {out_h, out}, {8'd4, 8'd28});
        chk("div_flags", {12'd0, flags}, 16'h0000);
        cycle(1, 4'hD, 8'h55, 8'h00);
        chk("div0_res", {out_h, out}, 16'h55FF);
        chk("div0_flags_busy", {11'd0, flags, busy}, 16'h000C);

        cycle(1, 4'h6, 8'h81, 8'h00);
        chk("rr", {7'd0, out, flags[1]}, {7'd0, 8'h40, 1'b1});
        cycle(1, 4'h7, 8'h81, 8'h00);
        chk("rl", {7'd0, out, flags[1]}, {7'd0, 8'h02, 1'b1});
        chk("rl_done", {15'd0, done}, 16'h0001);

        cycle(1, 4'hC, 8'h12, 8'h34);
        cycle(0, 4'h0, 8'h00, 8'h00);
        cycle(0, 4'h0, 8'h00, 8'h00);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_outs", {out_h, out}, 16'h0000);
        chk("abort_ctl", {10'd0, flags, busy, done}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DW + 2) cycle(0, 4'h0, 8'h00, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 3)] : DW'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 3)] : DW'($urandom);
            if (op == 4'hC && b == 0) b = 8'h01;
            if (op == 4'hD && $urandom_range(0, 7) == 0) b = 8'h00;
            cycle($urandom_range(0, 9) < 7, op, a, b);
        end
        cycle(0, 4'h0, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Parametrised, registered, multi-cycle successor to the single-cycle CPU ALU. Keeps the existing 4-bit opcode map for single-cycle operations (NOT..INC), registers the result and a flag word, and adds carry-chained add/subtract, compare, and iterative multiply/divide behind a START/BUSY/DONE handshake. It sits between the register file and the write-back path of the next-generation core, which stalls while BUSY is high.

## Interface
- IWIDTH, 4, opcode width (fixed encoding below; must be ≥4)
- DWIDTH, 8, operand/result width (≥4)
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  request; sampled only when BUSY=0
- IN_INSTR  in  IWIDTH  opcode, latched on accepted START
- IN_A  in  DWIDTH  operand A, latched on accepted START
- IN_B  in  DWIDTH  operand B, latched on accepted START
- OUT  out  DWIDTH  result (low half for MUL, quotient for DIV)
- OUT_H  out  DWIDTH  high half for MUL, remainder for DIV, else 0
- FLAGS  out  4  {V,N,C,Z}
- BUSY  out  1  multi-cycle operation in progress
- DONE  out  1  one-cycle pulse: OUT/OUT_H/FLAGS just updated

## Operation
- Opcodes: 0000 NOT A; 0001 XOR; 0010 OR; 0011 AND; 0100 SUB A-B; 0101 ADD A+B; 0110 RR (logical right by 1); 0111 RL (logical left by 1); 1000 DEC A-1; 1001 INC A+1; 1010 ADC A+B+C; 1011 SBB A-B-C; 1100 MUL (unsigned, 2·DWIDTH product); 1101 DIV (unsigned); 1110 CMP (A-B, flags only, OUT/OUT_H unchanged); 1111 PASS B.
- C in ADC/SBB is the registered FLAGS.C at the START edge.
- All arithmetic mod 2^DWIDTH; OUT_H=0 for every op except MUL/DIV (CMP leaves it unchanged).
- FSM: IDLE, RUN. IDLE+START with op 1100/1101 and B≠0 → RUN; all other accepted STARTs complete in IDLE. RUN → IDLE when iteration counter reaches 0.
- MUL: shift-add, one partial product per cycle, DWIDTH iterations.
- DIV: restoring, one quotient bit per cycle, DWIDTH iterations.
- DIV with B=0: no RUN; single-cycle completion, OUT=all ones, OUT_H=A, C=1.
- Flags on every completion: Z=(OUT==0) (CMP: difference==0); N=MSB of OUT (CMP: of difference).
- C: carry-out for ADD/ADC/INC; borrow for SUB/SBB/DEC/CMP; shifted-out bit for RR/RL; MUL: (OUT_H≠0); DIV: divide-by-zero; 0 for logic ops and PASS.
- V: signed overflow for ADD/ADC/SUB/SBB/INC/DEC/CMP; 0 otherwise.

## Timing
- Reset (async assert, sync-safe release): OUT=0, OUT_H=0, FLAGS=0000, BUSY=0, DONE=0, FSM=IDLE, counter=0.
- START accepted on rising edge E when BUSY=0. Single-cycle ops: results/FLAGS written at E, DONE=1 for the cycle after E, BUSY stays 0.
- MUL/DIV (B≠0 for DIV): BUSY=1 after E; iterations on edges E+1..E+DWIDTH; results written at E+DWIDTH, BUSY=0 and DONE=1 after that edge. Total latency DWIDTH edges after acceptance.
- OUT/OUT_H/FLAGS hold the previous result while BUSY=1; intermediate values are internal only.
- START while BUSY=1 ignored (no queueing); START in the DONE cycle is accepted (back-to-back throughput 1/cycle for single-cycle ops).
- IN_* changes after acceptance have no effect on the running operation.
- RST_N low mid-RUN aborts immediately to reset values; no DONE pulse.
- DONE never asserts without a preceding accepted START.

## Test plan
- Reset: drive RST_N low mid-MUL → all outputs 0 within the same cycle, no DONE after release.
- DWIDTH=8, ADD A=0xFF B=0x01 → OUT=0x00, FLAGS Z=1 C=1 V=0; next ADC A=0x10 B=0x20 → OUT=0x31, C=0, DONE one cycle each.
- SUB A=0x80 B=0x01 → OUT=0x7F, V=1 C=0 N=0; CMP A=0x05 B=0x05 → Z=1, OUT unchanged at 0x7F.
- MUL A=0xFF B=0xFF → BUSY 8 cycles, OUT=0x01, OUT_H=0xFE, C=1; START pulsed mid-RUN with ADD is ignored.
- DIV A=200 B=7 → after 8 cycles OUT=28, OUT_H=4, C=0; DIV A=0x55 B=0 → next cycle OUT=0xFF, OUT_H=0x55, C=1, BUSY never high.
- RR A=0x81 → OUT=0x40, C=1; RL A=0x81 → OUT=0x02, C=1; back-to-back STARTs give DONE on consecutive cycles.
